ip_amba_axi_master_wdata_chnl: RTL and testbench

//  AXI master write-data channel engine. Takes burst lengths from each accepted AW

---
 rtl/ip_amba_axi_master_wdata_chnl_if.sv | 28 ++
 rtl/ip_amba_axi_master_wdata_chnl.sv | 163 ++++++++++++++++
 tb/tb_ip_amba_axi_master_wdata_chnl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ip_amba_axi_master_wdata_chnl_if.sv
// AXI write-data channel signal bundle shared between the W engine and its sink.
interface ip_amba_axi_master_wdata_chnl_if #(
    parameter int unsigned WDATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = WDATA_WIDTH / 8;

    logic [WDATA_WIDTH-1:0] WDATA;
    logic [STRB_WIDTH-1:0]  WSTRB;
    logic                   WLAST;
    logic                   WVALID;
    logic                   WREADY;

    modport master (
        output WDATA,
        output WSTRB,
        output WLAST,
        output WVALID,
        input  WREADY
    );

    modport slave (
        input  WDATA,
        input  WSTRB,
        input  WLAST,
        input  WVALID,
        output WREADY
    );
endinterface

// File: rtl/ip_amba_axi_master_wdata_chnl.sv
// AXI master W-channel engine: queues AWLEN per accepted AW, then streams beats
// from a show-ahead WDATA FIFO in AW order with registered W outputs.
module ip_amba_axi_master_wdata_chnl #(
    parameter int unsigned WDATA_WIDTH = 32,
    parameter int unsigned LENQ_DEPTH  = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       aw_fire,
    input  logic [7:0]                 aw_len,
    output logic                       lenq_full,
    input  logic [WDATA_WIDTH-1:0]     fifo_data,
    input  logic [WDATA_WIDTH/8-1:0]   fifo_strb,
    input  logic                       fifo_empty,
    output logic                       fifo_pop,
    ip_amba_axi_master_wdata_chnl_if.master axi_w,
    output logic                       busy,
    output logic                       lenq_ovf_err
);
    localparam int unsigned STRB_WIDTH = WDATA_WIDTH / 8;
    localparam int unsigned PTR_W      = $clog2(LENQ_DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_BEAT, ST_STALL} state_t;

    state_t                  r_state;
    logic [WDATA_WIDTH-1:0]  r_wdata;
    logic [STRB_WIDTH-1:0]   r_wstrb;
    logic                    r_wlast;
    logic                    r_wvalid;
    logic [7:0]              r_beat_cnt;
    logic                    r_ovf_err;
    logic [7:0]              r_lenq [LENQ_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_cnt;

    logic                    w_lenq_empty;
    logic                    w_lenq_full;
    logic                    w_hs;
    logic                    w_load_beat;
    logic                    w_load_burst;
    logic                    w_push;
    logic                    w_ovf;
    logic [7:0]              w_head_len;

    assign w_lenq_empty = (r_cnt == '0);
    assign w_lenq_full  = (r_cnt == CNT_W'(LENQ_DEPTH));
    assign w_hs         = r_wvalid && axi_w.WREADY;
    assign w_head_len   = r_lenq[r_rd_ptr];

    // Decide this cycle's FIFO consumption: a new burst head or a continuation beat
    always_comb begin
        w_load_beat  = 1'b0;
        w_load_burst = 1'b0;
        case (r_state)
            ST_IDLE:  w_load_burst = !w_lenq_empty && !fifo_empty;
            ST_BEAT: begin
                if (w_hs) begin
                    if (r_wlast) w_load_burst = !w_lenq_empty && !fifo_empty;
                    else         w_load_beat  = !fifo_empty;
                end
            end
            ST_STALL: w_load_beat = !fifo_empty;
            default: begin
                w_load_beat  = 1'b0;
                w_load_burst = 1'b0;
            end
        endcase
    end

    // A push into a full queue is only legal when the engine pops in the same cycle
    assign w_push = aw_fire && (!w_lenq_full || w_load_burst);
    assign w_ovf  = aw_fire && w_lenq_full && !w_load_burst;

    always_ff @(posedge ACLK) begin
        if (w_push) r_lenq[r_wr_ptr] <= aw_len;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cnt     <= '0;
            r_ovf_err <= 1'b0;
        end else begin
            if (w_push)       r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_load_burst) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_load_burst);
            if (w_ovf) r_ovf_err <= 1'b1;
        end
    end

    // Beat engine: state plus registered W outputs
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state    <= ST_IDLE;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_wlast    <= 1'b0;
            r_wvalid   <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load_burst) begin
                        r_wdata    <= fifo_data;
                        r_wstrb    <= fifo_strb;
                        r_wvalid   <= 1'b1;
                        r_beat_cnt <= w_head_len;
                        r_wlast    <= (w_head_len == 8'd0);
                        r_state    <= ST_BEAT;
                    end
                end
                ST_BEAT: begin
                    if (w_hs) begin
                        if (r_wlast) begin
                            if (w_load_burst) begin
                                r_wdata    <= fifo_data;
                                r_wstrb    <= fifo_strb;
                                r_beat_cnt <= w_head_len;
                                r_wlast    <= (w_head_len == 8'd0);
                            end else begin
                                r_wvalid <= 1'b0;
                                r_wlast  <= 1'b0;
                                r_state  <= ST_IDLE;
                            end
                        end else if (w_load_beat) begin
                            r_wdata    <= fifo_data;
                            r_wstrb    <= fifo_strb;
                            r_beat_cnt <= r_beat_cnt - 8'd1;
                            r_wlast    <= (r_beat_cnt == 8'd1);
                        end else begin
                            r_wvalid <= 1'b0;
                            r_state  <= ST_STALL;
                        end
                    end
                end
                ST_STALL: begin
                    if (w_load_beat) begin
                        r_wdata    <= fifo_data;
                        r_wstrb    <= fifo_strb;
                        r_wvalid   <= 1'b1;
                        r_beat_cnt <= r_beat_cnt - 8'd1;
                        r_wlast    <= (r_beat_cnt == 8'd1);
                        r_state    <= ST_BEAT;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign fifo_pop     = w_load_beat || w_load_burst;
    assign lenq_full    = w_lenq_full;
    assign lenq_ovf_err = r_ovf_err;
    assign busy         = (r_state != ST_IDLE) || !w_lenq_empty;

    assign axi_w.WDATA  = r_wdata;
    assign axi_w.WSTRB  = r_wstrb;
    assign axi_w.WLAST  = r_wlast;
    assign axi_w.WVALID = r_wvalid;
endmodule

// File: tb/tb_ip_amba_axi_master_wdata_chnl.sv
// Directed bench for the AXI W-channel engine with a modelled show-ahead FIFO and beat log.
module tb_ip_amba_axi_master_wdata_chnl;
    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        aw_fire;
    logic [7:0]  aw_len;
    logic        lenq_full;
    logic [31:0] fifo_data;
    logic [3:0]  fifo_strb;
    logic        fifo_empty;
    logic        fifo_pop;
    logic        busy;
    logic        lenq_ovf_err;

    int checks = 0;
    int errors = 0;

    ip_amba_axi_master_wdata_chnl_if #(.WDATA_WIDTH(32)) axi_w ();

    ip_amba_axi_master_wdata_chnl #(.WDATA_WIDTH(32), .LENQ_DEPTH(4)) dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .aw_fire      (aw_fire),
        .aw_len       (aw_len),
        .lenq_full    (lenq_full),
        .fifo_data    (fifo_data),
        .fifo_strb    (fifo_strb),
        .fifo_empty   (fifo_empty),
        .fifo_pop     (fifo_pop),
        .axi_w        (axi_w),
        .busy         (busy),
        .lenq_ovf_err (lenq_ovf_err)
    );

    always #5 ACLK = ~ACLK;

    // Show-ahead FIFO model
    logic [31:0] fmem [64];
    logic [3:0]  fsmem [64];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_data  = fmem[rd_ptr[5:0]];
    assign fifo_strb  = fsmem[rd_ptr[5:0]];
    assign fifo_empty = (wr_ptr == rd_ptr);

    // W beat log
    int          cyc = 0;
    int          n_beats = 0;
    int          n_pops = 0;
    logic [31:0] bdata [64];
    logic        blast [64];
    int          bcyc [64];

    always @(posedge ACLK) begin
        cyc <= cyc + 1;
        if (ARESETn && axi_w.WVALID && axi_w.WREADY && n_beats < 64) begin
            bdata[n_beats] <= axi_w.WDATA;
            blast[n_beats] <= axi_w.WLAST;
            bcyc[n_beats]  <= cyc;
            n_beats        <= n_beats + 1;
        end
        if (fifo_pop) begin
            rd_ptr <= rd_ptr + 1;
            n_pops <= n_pops + 1;
        end
    end

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic fifo_put(input logic [31:0] d, input logic [3:0] s);
        fmem[wr_ptr[5:0]]  = d;
        fsmem[wr_ptr[5:0]] = s;
        wr_ptr             = wr_ptr + 1;
    endtask

    task automatic push(input logic [7:0] len);
        aw_len  = len;
        aw_fire = 1'b1;
        step();
        aw_fire = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while ((busy || axi_w.WVALID) && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (k >= budget) begin
            errors++;
            $display("FAIL %s timeout waiting for idle after %0d cycles", name, k);
        end
    endtask

    task automatic test_reset();
        checks++; if (axi_w.WVALID !== 1'b0) begin errors++; $display("FAIL reset_wvalid got %b exp 0", axi_w.WVALID); end
        checks++; if (axi_w.WLAST !== 1'b0) begin errors++; $display("FAIL reset_wlast got %b exp 0", axi_w.WLAST); end
        checks++; if (axi_w.WDATA !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", axi_w.WDATA); end
        checks++; if (axi_w.WSTRB !== 4'h0) begin errors++; $display("FAIL reset_wstrb got %h exp 0", axi_w.WSTRB); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (lenq_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", lenq_full); end
        checks++; if (lenq_ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", lenq_ovf_err); end
        checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_pop got %b exp 0", fifo_pop); end
    endtask

    task automatic test_single();
        int b = n_beats;
        fifo_put(32'hA5A5_0001, 4'b0110);
        axi_w.WREADY = 1'b1;
        push(8'd0);
        checks++; if (axi_w.WVALID !== 1'b0) begin errors++; $display("FAIL single_wvalid_n1 got %b exp 0", axi_w.WVALID); end
        checks++; if (fifo_pop !== 1'b1) begin errors++; $display("FAIL single_pop_n1 got %b exp 1", fifo_pop); end
        step();
        checks++; if (axi_w.WVALID !== 1'b1) begin errors++; $display("FAIL single_wvalid_n2 got %b exp 1", axi_w.WVALID); end
        checks++; if (axi_w.WDATA !== 32'hA5A5_0001) begin errors++; $display("FAIL single_wdata got %h exp a5a50001", axi_w.WDATA); end
        checks++; if (axi_w.WSTRB !== 4'b0110) begin errors++; $display("FAIL single_wstrb got %b exp 0110", axi_w.WSTRB); end
        checks++; if (axi_w.WLAST !== 1'b1) begin errors++; $display("FAIL single_wlast got %b exp 1", axi_w.WLAST); end
        step();
        checks++; if (axi_w.WVALID !== 1'b0) begin errors++; $display("FAIL single_wvalid_done got %b exp 0", axi_w.WVALID); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_done got %b exp 0", busy); end
        checks++; if (n_beats - b !== 1) begin errors++; $display("FAIL single_beats got %0d exp 1", n_beats - b); end
    endtask

    task automatic test_burst4();
        int b = n_beats;
        int p = n_pops;
        logic [31:0] exp_d [4];
        for (int k = 0; k < 4; k++) begin
            exp_d[k] = 32'hB000_0000 + 32'(k);
            fifo_put(exp_d[k], 4'hF);
        end
        axi_w.WREADY = 1'b1;
        push(8'd3);
        wait_idle(30, "burst4");
        checks++; if (n_beats - b !== 4) begin errors++; $display("FAIL burst4_beats got %0d exp 4", n_beats - b); end
        checks++; if (n_pops - p !== 4) begin errors++; $display("FAIL burst4_pops got %0d exp 4", n_pops - p); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (bdata[b+k] !== exp_d[k]) begin errors++; $display("FAIL burst4_data[%0d] got %h exp %h", k, bdata[b+k], exp_d[k]); end
            checks++; if (blast[b+k] !== (k == 3)) begin errors++; $display("FAIL burst4_last[%0d] got %b exp %b", k, blast[b+k], (k == 3)); end
        end
        checks++; if (bcyc[b+3] - bcyc[b] !== 3) begin errors++; $display("FAIL burst4_span got %0d exp 3", bcyc[b+3] - bcyc[b]); end
    endtask

    task automatic test_wready_stall();
        int b = n_beats;
        int p;
        for (int k = 0; k < 4; k++) fifo_put(32'hC000_0000 + 32'(k), 4'h3);
        axi_w.WREADY = 1'b1;
        push(8'd3);
        step();
        step();
        axi_w.WREADY = 1'b0;
        p = n_pops;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (axi_w.WDATA !== 32'hC000_0001) begin errors++; $display("FAIL wrstall_wdata[%0d] got %h exp c0000001", k, axi_w.WDATA); end
            checks++; if (axi_w.WLAST !== 1'b0 || axi_w.WVALID !== 1'b1) begin errors++; $display("FAIL wrstall_ctl[%0d] got last=%b valid=%b exp last=0 valid=1", k, axi_w.WLAST, axi_w.WVALID); end
            checks++; if (n_pops !== p) begin errors++; $display("FAIL wrstall_pops[%0d] got %0d exp %0d", k, n_pops, p); end
        end
        axi_w.WREADY = 1'b1;
        wait_idle(30, "wrstall");
        checks++; if (n_beats - b !== 4) begin errors++; $display("FAIL wrstall_beats got %0d exp 4", n_beats - b); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (bdata[b+k] !== 32'hC000_0000 + 32'(k)) begin errors++; $display("FAIL wrstall_data[%0d] got %h exp %h", k, bdata[b+k], 32'hC000_0000 + 32'(k)); end
        end
        checks++; if (blast[b+3] !== 1'b1 || blast[b+1] !== 1'b0) begin errors++; $display("FAIL wrstall_last got b2=%b b4=%b exp b2=0 b4=1", blast[b+1], blast[b+3]); end
    endtask

    task automatic test_fifo_stall();
        int b = n_beats;
        fifo_put(32'hD000_0000, 4'h1);
        axi_w.WREADY = 1'b1;
        push(8'd3);
        step();
        checks++; if (axi_w.WVALID !== 1'b1) begin errors++; $display("FAIL fstall_first got %b exp 1", axi_w.WVALID); end
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (axi_w.WVALID !== 1'b0 || axi_w.WLAST !== 1'b0) begin errors++; $display("FAIL fstall_hold[%0d] got valid=%b last=%b exp 0 0", k, axi_w.WVALID, axi_w.WLAST); end
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fstall_busy got %b exp 1", busy); end
        for (int k = 1; k < 4; k++) fifo_put(32'hD000_0000 + 32'(k), 4'h1);
        wait_idle(30, "fstall");
        checks++; if (n_beats - b !== 4) begin errors++; $display("FAIL fstall_beats got %0d exp 4", n_beats - b); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (bdata[b+k] !== 32'hD000_0000 + 32'(k) || blast[b+k] !== (k == 3)) begin errors++; $display("FAIL fstall_beat[%0d] got %h/%b exp %h/%b", k, bdata[b+k], blast[b+k], 32'hD000_0000 + 32'(k), (k == 3)); end
        end
    endtask

    task automatic test_back_to_back();
        int b = n_beats;
        for (int k = 0; k < 5; k++) fifo_put(32'hE000_0000 + 32'(k), 4'h8);
        axi_w.WREADY = 1'b1;
        push(8'd1);
        push(8'd2);
        wait_idle(30, "b2b");
        checks++; if (n_beats - b !== 5) begin errors++; $display("FAIL b2b_beats got %0d exp 5", n_beats - b); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (bdata[b+k] !== 32'hE000_0000 + 32'(k)) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", k, bdata[b+k], 32'hE000_0000 + 32'(k)); end
            checks++; if (blast[b+k] !== (k == 1 || k == 4)) begin errors++; $display("FAIL b2b_last[%0d] got %b exp %b", k, blast[b+k], (k == 1 || k == 4)); end
        end
        checks++; if (bcyc[b+4] - bcyc[b] !== 4) begin errors++; $display("FAIL b2b_bubble span got %0d exp 4", bcyc[b+4] - bcyc[b]); end
    endtask

    task automatic test_overflow_reset();
        axi_w.WREADY = 1'b0;
        for (int k = 0; k < 4; k++) push(8'd3);
        checks++; if (lenq_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", lenq_full); end
        checks++; if (lenq_ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", lenq_ovf_err); end
        push(8'd3);
        checks++; if (lenq_ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", lenq_ovf_err); end
        checks++; if (lenq_full !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ovf_state got full=%b busy=%b exp 1 1", lenq_full, busy); end
        fifo_put(32'hF000_0000, 4'hF);
        step();
        checks++; if (axi_w.WVALID !== 1'b1 || lenq_full !== 1'b0) begin errors++; $display("FAIL midburst got valid=%b full=%b exp 1 0", axi_w.WVALID, lenq_full); end
        ARESETn = 1'b0;
        #1;
        checks++; if (axi_w.WVALID !== 1'b0 || axi_w.WLAST !== 1'b0) begin errors++; $display("FAIL rst_ctl got valid=%b last=%b exp 0 0", axi_w.WVALID, axi_w.WLAST); end
        checks++; if (axi_w.WDATA !== 32'h0 || axi_w.WSTRB !== 4'h0) begin errors++; $display("FAIL rst_data got %h/%h exp 0/0", axi_w.WDATA, axi_w.WSTRB); end
        checks++; if (busy !== 1'b0 || lenq_full !== 1'b0 || lenq_ovf_err !== 1'b0) begin errors++; $display("FAIL rst_status got busy=%b full=%b ovf=%b exp 0 0 0", busy, lenq_full, lenq_ovf_err); end
        checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL rst_pop got %b exp 0", fifo_pop); end
        step();
        ARESETn = 1'b1;
        step();
    endtask

    initial begin
        ARESETn      = 1'b0;
        aw_fire      = 1'b0;
        aw_len       = 8'd0;
        axi_w.WREADY = 1'b0;
        repeat (3) step();
        ARESETn = 1'b1;
        step();
        test_reset();
        test_single();
        test_burst4();
        test_wready_stall();
        test_fifo_stall();
        test_back_to_back();
        test_overflow_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
